// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer
// Transaction-level I2C write master in front of the I2C_write_byte engine.
// Takes {address, length}, pulls payload bytes from a valid/ready stream and
// walks the engine through START, address byte, data bytes and STOP using the
// go/finish two-phase handshake. Slave ACK slots are handed to an external
// ack sampler through ack_req/ack_done.
module i2c_write_sequencer #(
  parameter int LEN_W       = 8,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             wb_go,
  output logic [2:0]       wb_command,
  output logic             wb_data,
  input  logic             wb_load,
  input  logic             wb_finish,
  output logic             ack_req,
  input  logic             ack_done,
  input  logic             ack_nack
);

  localparam int              TO_W    = $clog2(ACK_TIMEOUT + 1);
  // Last counter value of an ack slot: ack_req stays high for ACK_TIMEOUT cycles
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_STOP  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_FETCH,
    S_DATA,
    S_DATA_ACK,
    S_STOP
  } state_t;

  state_t           r_state;
  logic             r_release;     // 0: ISSUE phase, 1: RELEASE phase
  logic             r_err;         // a NACK or timeout happened in this transfer
  logic [6:0]       r_addr;
  logic [LEN_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [7:0]       r_shreg;

  logic             r_wb_go;
  logic [2:0]       r_wb_cmd;
  logic             r_ack_req;
  logic             r_busy;
  logic             r_req_ready;
  logic             r_done;
  logic             r_error;

  state_t           w_state_nxt;
  logic             w_release_nxt;
  logic             w_err_nxt;
  logic [6:0]       w_addr_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [TO_W-1:0]  w_to_nxt;
  logic [7:0]       w_shreg_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;
  logic             w_tx_ready;

  function automatic logic is_cmd_state(input state_t s);
    case (s)
      S_START, S_ADDR, S_DATA, S_STOP: is_cmd_state = 1'b1;
      default:                         is_cmd_state = 1'b0;
    endcase
  endfunction

  function automatic logic is_ack_state(input state_t s);
    case (s)
      S_ADDR_ACK, S_DATA_ACK: is_ack_state = 1'b1;
      default:                is_ack_state = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] cmd_of(input state_t s);
    case (s)
      S_START:        cmd_of = CMD_START;
      S_ADDR, S_DATA: cmd_of = CMD_WRITE;
      S_STOP:         cmd_of = CMD_STOP;
      default:        cmd_of = 3'b000;
    endcase
  endfunction

  // Next-state and datapath decisions for the transfer sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_release_nxt = r_release;
    w_err_nxt     = r_err;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_to_nxt      = {TO_W{1'b0}};
    w_shreg_nxt   = r_shreg;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
    w_tx_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt   = S_START;
          w_release_nxt = 1'b0;
          w_err_nxt     = 1'b0;
          w_addr_nxt    = req_addr;
          w_cnt_nxt     = req_len;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START, S_ADDR, S_DATA, S_STOP: begin
        if (!r_release) begin
          // ISSUE: the engine pulls one bit per low wb_load cycle
          if ((r_state == S_ADDR || r_state == S_DATA) && !wb_load) begin
            w_shreg_nxt = {r_shreg[6:0], 1'b0};
          end else begin
            w_shreg_nxt = r_shreg;
          end
          if (wb_finish) begin
            w_release_nxt = 1'b1;
          end else begin
            w_release_nxt = 1'b0;
          end
        end else if (!wb_finish) begin
          // RELEASE complete: the engine is ready for the next command
          w_release_nxt = 1'b0;
          case (r_state)
            S_START: begin
              w_state_nxt = S_ADDR;
              w_shreg_nxt = {r_addr, 1'b0};
            end
            S_ADDR:  w_state_nxt = S_ADDR_ACK;
            S_DATA:  w_state_nxt = S_DATA_ACK;
            default: begin
              w_state_nxt = S_IDLE;
              if (r_err) begin
                w_error_nxt = 1'b1;
              end else begin
                w_done_nxt = 1'b1;
              end
            end
          endcase
        end else begin
          w_release_nxt = 1'b1;
        end
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        if (ack_done) begin
          w_release_nxt = 1'b0;
          if (ack_nack) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_STOP;
          end else if (r_cnt == {LEN_W{1'b0}}) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else if (r_to_cnt == TO_LAST) begin
          // No answer from the sampler: treat the slot as a NACK
          w_release_nxt = 1'b0;
          w_err_nxt     = 1'b1;
          w_state_nxt   = S_STOP;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_FETCH: begin
        if (tx_valid) begin
          w_tx_ready    = 1'b1;
          w_shreg_nxt   = tx_data;
          w_cnt_nxt     = r_cnt - LEN_W'(1);
          w_state_nxt   = S_DATA;
          w_release_nxt = 1'b0;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_release_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_release <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= 7'h00;
      r_cnt     <= {LEN_W{1'b0}};
      r_to_cnt  <= {TO_W{1'b0}};
      r_shreg   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_release <= w_release_nxt;
      r_err     <= w_err_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_to_cnt  <= w_to_nxt;
      r_shreg   <= w_shreg_nxt;
    end
  end

  // Registered interface outputs, decoded from the upcoming state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb_go     <= 1'b0;
      r_wb_cmd    <= 3'b000;
      r_ack_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wb_go     <= is_cmd_state(w_state_nxt) && !w_release_nxt;
      r_wb_cmd    <= cmd_of(w_state_nxt);
      r_ack_req   <= is_ack_state(w_state_nxt);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign wb_go      = r_wb_go;
  assign wb_command = r_wb_cmd;
  assign wb_data    = r_shreg[7];
  assign ack_req    = r_ack_req;
  assign busy       = r_busy;
  assign req_ready  = r_req_ready;
  assign done       = r_done;
  assign error      = r_error;
  // Same-cycle handshake with the payload stream
  assign tx_ready   = w_tx_ready;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Testbench for i2c_write_sequencer: a behavioural byte engine, ack sampler
// and payload source surround the DUT; each transfer is compared against a
// transaction-level expectation built from the protocol rules.
module tb_i2c_write_sequencer;
  localparam int LEN_W       = 8;
  localparam int ACK_TIMEOUT = 1023;
  localparam int WAIT_MAX    = 5000;

  logic             clock, reset;
  logic             req_valid, req_ready;
  logic [6:0]       req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       tx_data;
  logic             tx_valid, tx_ready;
  logic             busy, done, error;
  logic             wb_go;
  logic [2:0]       wb_command;
  logic             wb_data, wb_load, wb_finish;
  logic             ack_req, ack_done, ack_nack;

  int checks = 0;
  int errors = 0;

  // observation
  logic [2:0] cmd_q[$];
  logic [7:0] byte_q[$];
  int         ackrun_q[$];
  int         tx_cnt = 0, done_cnt = 0, err_cnt = 0, hs_err = 0, ack_run = 0, stall_go = 0;
  // stimulus
  logic [7:0] tx_q[$];
  int         ack_plan[$];
  logic       tx_stall = 1'b0, tx_rand = 1'b0;
  logic [7:0] exp_bytes[$];
  int         exp_acks[$];   // per ack slot: 0 ACK, 1 NACK, 2 never answered
  string      obs_sig, exp_sig;
  // engine model state
  int         e_ph = 0, e_bit = 0, e_wait = 0, e_tmo = 0;
  logic [7:0] e_byte;
  logic [2:0] e_cmd;

  i2c_write_sequencer #(.LEN_W(LEN_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error),
    .wb_go(wb_go), .wb_command(wb_command), .wb_data(wb_data),
    .wb_load(wb_load), .wb_finish(wb_finish),
    .ack_req(ack_req), .ack_done(ack_done), .ack_nack(ack_nack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Byte engine model: logs commands, shifts in bytes MSB first via wb_load
  initial begin
    wb_finish = 1'b0;
    wb_load   = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        e_ph = 0; wb_finish = 1'b0; wb_load = 1'b1;
      end else begin
        case (e_ph)
          0: if (wb_go === 1'b1) begin
               e_cmd = wb_command; cmd_q.push_back(wb_command);
               e_bit = 0; e_byte = 8'h00; e_wait = $urandom_range(0, 3); e_tmo = 0; e_ph = 1;
             end
          1: begin
               if (wb_go !== 1'b1 || wb_command !== e_cmd) hs_err++;
               if (e_cmd == 3'b011) begin
                 if (!wb_load) begin
                   wb_load = 1'b1; e_bit++;
                 end else if (e_bit == 8) begin
                   byte_q.push_back(e_byte); wb_finish = 1'b1; e_ph = 2;
                 end else begin
                   e_byte = {e_byte[6:0], wb_data}; wb_load = 1'b0;
                 end
               end else if (e_wait > 0) begin
                 e_wait--;
               end else begin
                 wb_finish = 1'b1; e_ph = 2;
               end
             end
          2: if (wb_go === 1'b0) begin
               wb_finish = 1'b0; e_ph = 0;
             end else begin
               e_tmo++;
               if (e_tmo == 20) hs_err++;
             end
          default: e_ph = 0;
        endcase
      end
    end
  end

  // Ack sampler model: answers each ack slot according to ack_plan
  initial begin
    int a_ph, a_plan, a_dly;
    a_ph = 0; a_plan = 0; a_dly = 0;
    ack_done = 1'b0; ack_nack = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        a_ph = 0; ack_done = 1'b0; ack_nack = 1'b0;
      end else begin
        case (a_ph)
          0: if (ack_req === 1'b1) begin
               a_plan = (ack_plan.size() > 0) ? ack_plan.pop_front() : 0;
               a_dly = $urandom_range(0, 4); a_ph = 1;
             end
          1: if (a_plan == 2) begin
               if (ack_req !== 1'b1) a_ph = 0;
             end else if (a_dly > 0) begin
               a_dly--;
             end else begin
               ack_done = 1'b1; ack_nack = (a_plan == 1); a_ph = 2;
             end
          2: begin ack_done = 1'b0; ack_nack = 1'b0; a_ph = 0; end
          default: a_ph = 0;
        endcase
      end
    end
  end

  // Payload source: presents the head of tx_q, pops it once consumed
  initial begin
    logic took;
    tx_valid = 1'b0; tx_data = 8'h00;
    forever begin
      @(negedge clock);
      took = (tx_ready === 1'b1);
      @(posedge clock); #1;
      if (took && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_q.size() > 0 && !tx_stall && (!tx_rand || $urandom_range(0, 1) == 1)) begin
        tx_valid = 1'b1; tx_data = tx_q[0];
      end else begin
        tx_valid = 1'b0; tx_data = 8'h00;
      end
    end
  end

  // Pulse counters and ack_req run-length monitor
  initial begin
    forever begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
      if (error === 1'b1) err_cnt++;
      if (tx_ready === 1'b1) tx_cnt++;
      if (ack_req === 1'b1) begin
        ack_run++;
      end else if (ack_run > 0) begin
        ackrun_q.push_back(ack_run); ack_run = 0;
      end
    end
  end

  // Transaction-level expectation from address, length, payload and ack plan
  function automatic string model_sig(input logic [6:0] addr, input int len);
    string s_c, s_b;
    int txr, nack;
    txr = 0; nack = 0;
    s_c = $sformatf(" %03b %03b", 3'b001, 3'b011);
    s_b = $sformatf(" %02h", {addr, 1'b0});
    if (exp_acks[0] != 0) nack = 1;
    for (int i = 0; i < len && nack == 0; i++) begin
      s_c = $sformatf("%s %03b", s_c, 3'b011);
      s_b = $sformatf("%s %02h", s_b, exp_bytes[i]);
      txr++;
      if (exp_acks[i+1] != 0) nack = 1;
    end
    s_c = $sformatf("%s %03b", s_c, 3'b100);
    return $sformatf("cmd[%s] byte[%s] txr=%0d done=%0d err=%0d hs=%0d", s_c, s_b, txr, 1 - nack, nack, 0);
  endfunction

  function automatic string obs_string();
    string s_c, s_b;
    s_c = ""; s_b = "";
    foreach (cmd_q[i]) s_c = $sformatf("%s %03b", s_c, cmd_q[i]);
    foreach (byte_q[i]) s_b = $sformatf("%s %02h", s_b, byte_q[i]);
    return $sformatf("cmd[%s] byte[%s] txr=%0d done=%0d err=%0d hs=%0d", s_c, s_b, tx_cnt, done_cnt, err_cnt, hs_err);
  endfunction

  task automatic setup(input int len);
    exp_bytes.delete(); exp_acks.delete();
    for (int i = 0; i < len; i++) exp_bytes.push_back(8'($urandom));
    for (int i = 0; i <= len; i++) exp_acks.push_back(0);
  endtask

  task automatic clear_obs();
    cmd_q.delete(); byte_q.delete(); ackrun_q.delete();
    tx_cnt = 0; done_cnt = 0; err_cnt = 0; hs_err = 0; ack_run = 0; stall_go = 0;
  endtask

  // Runs one transfer; stall > 0 withholds the payload for that many cycles in FETCH
  task automatic do_txn(input logic [6:0] addr, input int len, input int stall);
    int k;
    clear_obs();
    ack_plan = exp_acks; tx_q = exp_bytes; tx_stall = (stall > 0);
    exp_sig = model_sig(addr, len);
    @(posedge clock); #1;
    req_addr = addr; req_len = LEN_W'(len); req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = 7'($urandom); req_len = LEN_W'($urandom);
    if (stall > 0) begin
      k = 0;
      while (ackrun_q.size() == 0 && k < WAIT_MAX) begin @(negedge clock); k++; end
      req_valid = 1'b1;   // a request offered while busy must be ignored
      for (int i = 0; i < stall; i++) begin
        @(negedge clock);
        if (wb_go !== 1'b0) stall_go++;
      end
      req_valid = 1'b0;
      tx_stall = 1'b0;
    end
    k = 0;
    while (done_cnt + err_cnt == 0 && k < WAIT_MAX) begin @(negedge clock); k++; end
    checks++;
    if (k >= WAIT_MAX) begin
      errors++;
      $display("FAIL txn_wait: no done/error after %0d cycles, required within %0d", k, WAIT_MAX);
    end
    @(negedge clock);
    obs_sig = obs_string();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({wb_go, wb_command, ack_req, tx_ready, busy, done, error, wb_data, req_ready} !== 11'b000_0000_0001) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required %b",
               {wb_go, wb_command, ack_req, tx_ready, busy, done, error, wb_data, req_ready}, 11'b000_0000_0001);
    end
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({wb_go, busy, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL idle_after_reset: got go/busy/ready=%b, required 001", {wb_go, busy, req_ready});
    end
  endtask

  task automatic test_write_two_bytes();
    setup(2);
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h3C;
    do_txn(7'h50, 2, 0);
    checks++;
    if (obs_sig != exp_sig) begin
      errors++; $display("FAIL write_a5_3c: got %s, required %s", obs_sig, exp_sig);
    end
    checks++;
    if ({busy, req_ready} !== 2'b01) begin
      errors++; $display("FAIL write_idle_after: got busy/ready=%b, required 01", {busy, req_ready});
    end
  endtask

  task automatic test_probe();
    setup(0);
    do_txn(7'h2A, 0, 0);
    checks++;
    if (obs_sig != exp_sig) begin
      errors++; $display("FAIL probe_len0: got %s, required %s", obs_sig, exp_sig);
    end
  endtask

  task automatic test_nack();
    setup(3);
    exp_acks[2] = 1;
    do_txn(7'($urandom), 3, 0);
    checks++;
    if (obs_sig != exp_sig) begin
      errors++; $display("FAIL nack_byte2: got %s, required %s", obs_sig, exp_sig);
    end
  endtask

  task automatic test_timeout();
    setup(1);
    exp_acks[0] = 2;
    do_txn(7'($urandom), 1, 0);
    checks++;
    if (obs_sig != exp_sig) begin
      errors++; $display("FAIL timeout_seq: got %s, required %s", obs_sig, exp_sig);
    end
    checks++;
    if (ackrun_q.size() != 1 || ackrun_q[0] != ACK_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len: got %0d slots, first %0d cycles, required 1 slot of %0d cycles",
               ackrun_q.size(), (ackrun_q.size() > 0) ? ackrun_q[0] : -1, ACK_TIMEOUT);
    end
  endtask

  task automatic test_stall();
    setup(2);
    do_txn(7'($urandom), 2, 50);
    checks++;
    if (stall_go != 0) begin
      errors++; $display("FAIL stall_go: got %0d go cycles during stall, required 0", stall_go);
    end
    checks++;
    if (obs_sig != exp_sig) begin
      errors++; $display("FAIL stall_resume: got %s, required %s", obs_sig, exp_sig);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    setup(2);
    clear_obs();
    ack_plan = exp_acks; tx_q = exp_bytes; tx_stall = 1'b0;
    @(posedge clock); #1;
    req_addr = 7'($urandom); req_len = LEN_W'(2); req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    k = 0;
    while (!(cmd_q.size() == 3 && e_ph == 1 && e_bit == 3) && k < WAIT_MAX) begin
      @(negedge clock); k++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wb_go, busy, req_ready, ack_req, tx_ready, done, error} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got go/busy/ready/ackreq/txready/done/error=%b, required 0010000",
               {wb_go, busy, req_ready, ack_req, tx_ready, done, error});
    end
    tx_q.delete(); ack_plan.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if (cmd_q.size() != 3 || done_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_no_stop: got %0d cmds done=%0d err=%0d, required 3 cmds done=0 err=0",
               cmd_q.size(), done_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      setup(t + 1);
      do_txn(7'($urandom), t + 1, 0);
      checks++;
      if (obs_sig != exp_sig) begin
        errors++; $display("FAIL back_to_back_%0d: got %s, required %s", t, obs_sig, exp_sig);
      end
    end
  endtask

  task automatic test_random();
    int len, r;
    tx_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 5);
      setup(len);
      for (int s = 0; s <= len; s++) begin
        r = $urandom_range(0, 29);
        exp_acks[s] = (r < 3) ? 1 : ((r == 3) ? 2 : 0);
      end
      do_txn(7'($urandom), len, 0);
      checks++;
      if (obs_sig != exp_sig) begin
        errors++; $display("FAIL random_%0d: got %s, required %s", t, obs_sig, exp_sig);
      end
    end
    tx_rand = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 7'h00; req_len = {LEN_W{1'b0}};
    test_reset();
    test_write_two_bytes();
    test_probe();
    test_nack();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
